// File: rtl/vector_sequencer.sv
// On-board vector sequencer: replays {rst, gpio_in, expected} words from a
// synchronous ROM into the cpu GPIO datapath and tallies mismatches.
module vector_sequencer #(
    parameter int NUM_VEC = 150,
    parameter int ADDR_W  = 8,
    parameter int SETTLE  = 6
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [64:0]       vec_data,
    output logic              dut_rst,
    output logic [31:0]       dut_gpio_in,
    input  logic [31:0]       dut_gpio_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       error_count,
    output logic [31:0]       vector_num,
    output logic              mismatch_valid,
    output logic [ADDR_W-1:0] mismatch_index,
    output logic [31:0]       mismatch_got,
    output logic [31:0]       mismatch_exp
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_dut_rst;
    logic [31:0]       r_gpio_in;
    logic [31:0]       r_exp;
    logic [31:0]       r_err;
    logic [31:0]       r_vnum;
    logic              r_mm_valid;
    logic [ADDR_W-1:0] r_mm_idx;
    logic [31:0]       r_mm_got;
    logic [31:0]       r_mm_exp;

    logic w_start;
    logic w_load;
    logic w_check;
    logic w_sentinel;
    logic w_last;
    logic w_miss;

    assign w_sentinel = &vec_data;
    assign w_last     = (r_addr == LAST_ADDR);
    // A vector that holds the cpu in reset has no meaningful gpio_out.
    assign w_miss     = !r_dut_rst && (dut_gpio_out != r_exp);

    always_ff @(posedge clk2) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_load  = 1'b0;
        w_check = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_start = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_FETCH: w_next = S_LOAD;
            S_LOAD: begin
                if (w_sentinel) begin
                    w_next = S_DONE;
                end else begin
                    w_load = 1'b1;
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_check = 1'b1;
                w_next  = w_last ? S_DONE : S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk2) begin
        if (!rst) begin
            r_addr     <= '0;
            r_cnt      <= '0;
            r_dut_rst  <= 1'b1;
            r_gpio_in  <= '0;
            r_exp      <= '0;
            r_err      <= '0;
            r_vnum     <= '0;
            r_mm_valid <= 1'b0;
            r_mm_idx   <= '0;
            r_mm_got   <= '0;
            r_mm_exp   <= '0;
        end else begin
            r_mm_valid <= 1'b0;
            if (w_start) begin
                r_addr <= '0;
                r_err  <= '0;
                r_vnum <= '0;
            end
            if (w_load) begin
                r_dut_rst <= vec_data[64];
                r_gpio_in <= vec_data[63:32];
                r_exp     <= vec_data[31:0];
                r_cnt     <= CNT_LOAD;
            end
            if (r_state == S_SETTLE && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_check) begin
                r_vnum <= r_vnum + 32'd1;
                if (w_miss) begin
                    r_mm_valid <= 1'b1;
                    r_mm_idx   <= r_addr;
                    r_mm_got   <= dut_gpio_out;
                    r_mm_exp   <= r_exp;
                    if (r_err != 32'hFFFF_FFFF) begin
                        r_err <= r_err + 32'd1;
                    end
                end
                if (!w_last) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    assign vec_addr       = r_addr;
    assign dut_rst        = r_dut_rst;
    assign dut_gpio_in    = r_gpio_in;
    assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done           = (r_state == S_DONE);
    assign pass           = done && (r_err == '0);
    assign error_count    = r_err;
    assign vector_num     = r_vnum;
    assign mismatch_valid = r_mm_valid;
    assign mismatch_index = r_mm_idx;
    assign mismatch_got   = r_mm_got;
    assign mismatch_exp   = r_mm_exp;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: ROM and a 2-cycle gpio echo model
// surround the sequencer; each step asserts hand-computed values.
module tb_vector_sequencer;

    localparam int ADDR_W = 8;

    logic              clk2;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] vec_addr;
    logic [64:0]       vec_data;
    logic              dut_rst;
    logic [31:0]       dut_gpio_in;
    logic [31:0]       dut_gpio_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [31:0]       error_count;
    logic [31:0]       vector_num;
    logic              mismatch_valid;
    logic [ADDR_W-1:0] mismatch_index;
    logic [31:0]       mismatch_got;
    logic [31:0]       mismatch_exp;

    logic [64:0] rom [0:255];
    logic [31:0] echo_d1;

    int nchk  = 0;
    int npass = 0;
    int pulses;
    int peak;
    int n;
    logic [ADDR_W-1:0] cap_idx;
    logic [31:0]       cap_got;
    logic [31:0]       cap_exp;

    vector_sequencer #(
        .NUM_VEC(4),
        .ADDR_W (ADDR_W),
        .SETTLE (6)
    ) u_dut (
        .clk2          (clk2),
        .rst           (rst),
        .start         (start),
        .vec_addr      (vec_addr),
        .vec_data      (vec_data),
        .dut_rst       (dut_rst),
        .dut_gpio_in   (dut_gpio_in),
        .dut_gpio_out  (dut_gpio_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .error_count   (error_count),
        .vector_num    (vector_num),
        .mismatch_valid(mismatch_valid),
        .mismatch_index(mismatch_index),
        .mismatch_got  (mismatch_got),
        .mismatch_exp  (mismatch_exp)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    always @(posedge clk2) vec_data <= rom[vec_addr];

    always @(posedge clk2) begin
        echo_d1      <= dut_gpio_in;
        dut_gpio_out <= echo_d1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk2);
        #1;
    endtask

    task automatic run_to_done(input int max_edges, output int edges);
        edges  = 0;
        pulses = 0;
        peak   = int'(vec_addr);
        while (!done && edges < max_edges) begin
            step();
            edges++;
            if (mismatch_valid) begin
                pulses++;
                cap_idx = mismatch_index;
                cap_got = mismatch_got;
                cap_exp = mismatch_exp;
            end
            if (int'(vec_addr) > peak) peak = int'(vec_addr);
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '1;
        rom[0] = {1'b1, 32'h0000_0000, 32'h0000_0000};
        rom[1] = {1'b0, 32'h0002_6789, 32'h0002_6789};
        rom[2] = {1'b0, 32'h0000_0001, 32'h0000_0001};

        // reset with start held high
        rst   = 1'b0;
        start = 1'b1;
        step();
        step();
        chk("rst_addr",  64'(vec_addr), 64'd0);
        chk("rst_drst",  64'(dut_rst), 64'd1);
        chk("rst_gin",   64'(dut_gpio_in), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_pass",  64'(pass), 64'd0);
        chk("rst_mv",    64'(mismatch_valid), 64'd0);
        chk("rst_err",   64'(error_count), 64'd0);
        chk("rst_vnum",  64'(vector_num), 64'd0);
        chk("rst_midx",  64'(mismatch_index), 64'd0);
        chk("rst_mgot",  64'(mismatch_got), 64'd0);
        chk("rst_mexp",  64'(mismatch_exp), 64'd0);

        // clean run with sentinel at index 3
        rst = 1'b1;
        step();
        chk("start_busy", 64'(busy), 64'd1);
        start = 1'b0;
        run_to_done(200, n);
        chk("clean_edges", 64'(n), 64'd29);
        chk("clean_vnum",  64'(vector_num), 64'd3);
        chk("clean_err",   64'(error_count), 64'd0);
        chk("clean_pass",  64'(pass), 64'd1);
        chk("clean_pulse", 64'(pulses), 64'd0);
        chk("clean_busy",  64'(busy), 64'd0);

        // mismatch on vector 1
        rom[1] = {1'b0, 32'h0002_6789, 32'h0002_6788};
        kick();
        run_to_done(200, n);
        chk("mm_edges", 64'(n), 64'd29);
        chk("mm_pulse", 64'(pulses), 64'd1);
        chk("mm_idx",   64'(cap_idx), 64'd1);
        chk("mm_got",   64'(cap_got), 64'h0002_6789);
        chk("mm_exp",   64'(cap_exp), 64'h0002_6788);
        chk("mm_err",   64'(error_count), 64'd1);
        chk("mm_pass",  64'(pass), 64'd0);
        chk("mm_hold",  64'(mismatch_index), 64'd1);

        // reset-bit vector: expected field ignored
        rom[0] = {1'b1, 32'h0003_FFFF, 32'hDEAD_BEEF};
        rom[1] = {1'b0, 32'h0002_6789, 32'h0002_6789};
        kick();
        step();
        step();
        step();
        chk("rb_drst", 64'(dut_rst), 64'd1);
        chk("rb_gin",  64'(dut_gpio_in), 64'h0003_FFFF);
        run_to_done(200, n);
        chk("rb_pulse", 64'(pulses), 64'd0);
        chk("rb_err",   64'(error_count), 64'd0);
        chk("rb_pass",  64'(pass), 64'd1);

        // no sentinel: NUM_VEC hard stop
        rom[0] = {1'b1, 32'h0000_0000, 32'h0000_0000};
        rom[3] = {1'b0, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
        kick();
        run_to_done(200, n);
        chk("nv_edges", 64'(n), 64'd36);
        chk("nv_vnum",  64'(vector_num), 64'd4);
        chk("nv_peak",  64'(peak), 64'd3);
        chk("nv_addr",  64'(vec_addr), 64'd3);
        chk("nv_pass",  64'(pass), 64'd1);

        // reset during SETTLE of vector 2
        kick();
        for (int i = 0; i < 22; i++) step();
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_vnum", 64'(vector_num), 64'd2);
        rst = 1'b0;
        step();
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_done", 64'(done), 64'd0);
        chk("mr_vnum", 64'(vector_num), 64'd0);
        chk("mr_err",  64'(error_count), 64'd0);
        chk("mr_addr", 64'(vec_addr), 64'd0);
        chk("mr_drst", 64'(dut_rst), 64'd1);
        chk("mr_gin",  64'(dut_gpio_in), 64'd0);
        rst = 1'b1;
        kick();
        chk("rs_addr", 64'(vec_addr), 64'd0);
        chk("rs_busy", 64'(busy), 64'd1);
        run_to_done(200, n);
        chk("rs_edges", 64'(n), 64'd36);
        chk("rs_vnum",  64'(vector_num), 64'd4);
        chk("rs_err",   64'(error_count), 64'd0);
        chk("rs_pass",  64'(pass), 64'd1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
